// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame reader.
//   tx_state_e    : frame-reader FSM states
//   *_BYTE        : fixed bytes driven on GMII around the payload
//   max3()        : sizing helper for the shared phase counter
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_PAD      = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_IFG      = 3'd6
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] PAD_BYTE      = 8'h00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eth_tx_frame_reader.sv
// Drains complete frames from the TX packet FIFO onto GMII.
// Adds preamble/SFD, zero-pads short payloads, enforces the inter-frame gap
// and pulses pct_txed back to the packet-count tracker once per frame.
// Ports:
//   eth_tx_clk, rst          : clock, synchronous active-high reset
//   bf_in_buffer_ready[1:0]  : complete frames queued in the FIFO
//   fifo_rd_data/last/empty  : FWFT FIFO head
//   fifo_rd_en               : pop head this cycle (combinational)
//   gmii_txd/tx_en/tx_er     : registered GMII outputs
//   bf_out_pct_txed          : one pulse per frame, first IFG cycle
//   underrun                 : one pulse when the FIFO runs dry mid-payload
//   busy                     : FSM not idle
module eth_tx_frame_reader
    import eth_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       eth_tx_clk,
    input  logic       rst,
    input  logic [1:0] bf_in_buffer_ready,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_rd_last,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       bf_out_pct_txed,
    output logic       underrun,
    output logic       busy
);

    localparam int CW = $clog2(max3(PREAMBLE_LEN, MIN_PAYLOAD, IFG_CYCLES) + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] PAY_MIN  = CW'(MIN_PAYLOAD);
    localparam logic [CW-1:0] PAY_LAST = CW'(MIN_PAYLOAD - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    tx_state_e     state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [7:0]    nxt_txd;
    logic          nxt_en, nxt_er, nxt_under, pop;

    // Each state's action is registered onto GMII, so the wire trails the
    // state by one cycle. In PAYLOAD/PAD the counter holds bytes driven so far.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_txd   = PAD_BYTE;
        nxt_en    = 1'b0;
        nxt_er    = 1'b0;
        nxt_under = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bf_in_buffer_ready != 2'd0 && !fifo_empty) begin
                    nxt_state = ST_PREAMBLE;
                    nxt_cnt   = '0;
                end
            end
            ST_PREAMBLE: begin
                nxt_txd = PREAMBLE_BYTE;
                nxt_en  = 1'b1;
                nxt_cnt = cnt + ONE;
                if (cnt == PRE_LAST) begin
                    nxt_state = ST_SFD;
                    nxt_cnt   = '0;
                end
            end
            ST_SFD: begin
                nxt_txd   = SFD_BYTE;
                nxt_en    = 1'b1;
                nxt_state = ST_PAYLOAD;
                nxt_cnt   = '0;
            end
            ST_PAYLOAD: begin
                nxt_en = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    nxt_txd = fifo_rd_data;
                    nxt_cnt = (cnt == PAY_MIN) ? cnt : cnt + ONE;
                    if (fifo_rd_last) begin
                        // cnt >= MIN-1 means this byte reaches the minimum
                        if (cnt >= PAY_LAST) begin
                            nxt_state = ST_IFG;
                            nxt_cnt   = '0;
                        end else begin
                            nxt_state = ST_PAD;
                        end
                    end
                end else begin
                    // Poison the byte; the rest of the frame is discarded
                    nxt_er    = 1'b1;
                    nxt_under = 1'b1;
                    nxt_state = ST_DRAIN;
                    nxt_cnt   = '0;
                end
            end
            ST_PAD: begin
                nxt_en  = 1'b1;
                nxt_cnt = cnt + ONE;
                if (cnt == PAY_LAST) begin
                    nxt_state = ST_IFG;
                    nxt_cnt   = '0;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_rd_last) begin
                        nxt_state = ST_IFG;
                        nxt_cnt   = '0;
                    end
                end
            end
            ST_IFG: begin
                nxt_cnt = cnt + ONE;
                if (cnt == IFG_LAST) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Reset must block pops even though the FSM only clears on the edge
    assign fifo_rd_en = pop && !rst;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge eth_tx_clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            gmii_txd        <= 8'h00;
            gmii_tx_en      <= 1'b0;
            gmii_tx_er      <= 1'b0;
            bf_out_pct_txed <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            gmii_txd        <= nxt_txd;
            gmii_tx_en      <= nxt_en;
            gmii_tx_er      <= nxt_er;
            bf_out_pct_txed <= (nxt_state == ST_IFG) && (state != ST_IFG);
            underrun        <= nxt_under;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_reader.sv
module tb_eth_tx_frame_reader;

    localparam int PRE  = 7;
    localparam int MINP = 60;
    localparam int IFG  = 12;

    logic       eth_tx_clk = 1'b0;
    logic       rst;
    logic [1:0] bf_in_buffer_ready;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_last;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       bf_out_pct_txed;
    logic       underrun;
    logic       busy;

    eth_tx_frame_reader #(
        .PREAMBLE_LEN(PRE), .MIN_PAYLOAD(MINP), .IFG_CYCLES(IFG)
    ) dut (
        .eth_tx_clk        (eth_tx_clk),
        .rst               (rst),
        .bf_in_buffer_ready(bf_in_buffer_ready),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_last      (fifo_rd_last),
        .fifo_empty        (fifo_empty),
        .fifo_rd_en        (fifo_rd_en),
        .gmii_txd          (gmii_txd),
        .gmii_tx_en        (gmii_tx_en),
        .gmii_tx_er        (gmii_tx_er),
        .bf_out_pct_txed   (bf_out_pct_txed),
        .underrun          (underrun),
        .busy              (busy)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;

    int total = 0;
    int bad   = 0;

    // FIFO + tracker model
    logic [8:0] q[$];
    int  tracked   = 0;
    int  pop_total = 0;
    int  rd_bad    = 0;
    int  starve_at = -1;
    int  frame_base = 0;
    bit  hold0     = 1'b0;
    bit  starve;

    // expected wire bytes (tx_en=1 cycles) and captured wire
    logic [7:0] exp_q[$];
    logic       cap_en[$];
    logic [7:0] cap_txd[$];
    logic       cap_er[$];
    int         cap_pct, cap_und;
    bit         cap_timeout;

    always @(posedge eth_tx_clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) rd_bad++;
            else if (q.size() > 0) begin
                void'(q.pop_front());
                pop_total++;
            end
        end
        if (bf_out_pct_txed && tracked > 0) tracked--;
        #1;
        starve = (starve_at >= 0) && (pop_total - frame_base == starve_at);
        if (starve) starve_at = -1;
        if (q.size() > 0) begin
            fifo_rd_data = q[0][7:0];
            fifo_rd_last = q[0][8];
        end else begin
            fifo_rd_data = 8'h00;
            fifo_rd_last = 1'b0;
        end
        fifo_empty         = (q.size() == 0) || starve;
        bf_in_buffer_ready = hold0 ? 2'd0 : ((tracked > 3) ? 2'd3 : 2'(tracked));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Queue a random frame and append what the wire must show for it.
    // cut >= 0: FIFO runs dry when payload byte 'cut' is at the head.
    task automatic push_frame(input int len, input int cut);
        logic [7:0] pl[$];
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pl.push_back(b);
            q.push_back({(i == len - 1), b});
        end
        tracked++;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        if (cut < 0) begin
            foreach (pl[i]) exp_q.push_back(pl[i]);
            for (int i = len; i < MINP; i++) exp_q.push_back(8'h00);
        end else begin
            for (int i = 0; i < cut; i++) exp_q.push_back(pl[i]);
            exp_q.push_back(8'h00);
        end
    endtask

    task automatic capture(input int nframes, input int budget);
        cap_en.delete(); cap_txd.delete(); cap_er.delete();
        cap_pct = 0; cap_und = 0; cap_timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge eth_tx_clk);
            cap_en.push_back(gmii_tx_en);
            cap_txd.push_back(gmii_txd);
            cap_er.push_back(gmii_tx_er);
            cap_pct += int'(bf_out_pct_txed);
            cap_und += int'(underrun);
            if (cap_pct == nframes && !busy) begin
                cap_timeout = 1'b0;
                break;
            end
        end
        chk("capture_done", 32'(cap_timeout), 32'd0);
    endtask

    task automatic check_wire(input string tag, input int nframes, input int nund);
        int n_en = 0;
        int n_er = 0;
        int mism = -1;
        foreach (cap_en[i]) begin
            if (cap_er[i]) n_er++;
            if (cap_en[i] === 1'b1) begin
                if (n_en < exp_q.size() && cap_txd[i] !== exp_q[n_en] && mism < 0) mism = n_en;
                n_en++;
            end
        end
        chk({tag, "_en_cycles"}, n_en, exp_q.size());
        chk({tag, "_first_bad_byte"}, mism, -1);
        chk({tag, "_pct"}, cap_pct, nframes);
        chk({tag, "_underrun"}, cap_und, nund);
        chk({tag, "_tx_er"}, n_er, nund);
        chk({tag, "_fifo_left"}, q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int fall, rise, p0, pct_seen, rd_cnt, en_cnt;
        bit reached;
        rst = 1'b1;
        bf_in_buffer_ready = 2'd0;
        fifo_rd_data = 8'h00;
        fifo_rd_last = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) @(negedge eth_tx_clk);
        chk("rst_txd", gmii_txd, 0);
        chk("rst_en", gmii_tx_en, 0);
        chk("rst_er", gmii_tx_er, 0);
        chk("rst_pct", bf_out_pct_txed, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // 64-byte frame
        push_frame(64, -1);
        capture(1, 300);
        check_wire("t1", 1, 0);

        // short frame, padded
        push_frame(10, -1);
        capture(1, 300);
        check_wire("t2", 1, 0);

        // back-to-back frames: idle gap on the wire
        push_frame(60, -1);
        push_frame(60, -1);
        capture(2, 600);
        fall = -1; rise = -1;
        for (int i = 1; i < cap_en.size(); i++) begin
            if (fall < 0 && cap_en[i] === 1'b0 && cap_en[i-1] === 1'b1) fall = i;
            else if (fall >= 0 && rise < 0 && cap_en[i] === 1'b1) rise = i;
        end
        chk("t3_gap", rise - fall, IFG + 1);
        check_wire("t3", 2, 0);

        // underrun at payload byte 20
        frame_base = pop_total;
        starve_at = 20;
        push_frame(64, 20);
        capture(1, 300);
        check_wire("t4", 1, 1);
        chk("t4_popped", pop_total - frame_base, 64);

        // reset during payload byte 30
        frame_base = pop_total;
        push_frame(64, -1);
        exp_q.delete();
        reached = 1'b0; pct_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge eth_tx_clk);
            pct_seen += int'(bf_out_pct_txed);
            if (pop_total - frame_base >= 30) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t5_reached", 32'(reached), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rd_en_in_rst", fifo_rd_en, 0);
        p0 = pop_total;
        q.delete();
        tracked = 0;
        @(negedge eth_tx_clk);
        pct_seen += int'(bf_out_pct_txed);
        chk("t5_en", gmii_tx_en, 0);
        chk("t5_busy", busy, 0);
        @(negedge eth_tx_clk);
        pct_seen += int'(bf_out_pct_txed);
        chk("t5_no_pop", pop_total, p0);
        chk("t5_no_pct", pct_seen, 0);
        rst = 1'b0;
        repeat (3) @(negedge eth_tx_clk);
        chk("t5_idle_after", busy, 0);

        // nothing ready: frame must stay in FIFO
        hold0 = 1'b1;
        push_frame(30, -1);
        rd_cnt = 0; en_cnt = 0;
        repeat (100) begin
            @(negedge eth_tx_clk);
            rd_cnt += int'(fifo_rd_en);
            en_cnt += int'(gmii_tx_en);
        end
        chk("t6_rd_en", rd_cnt, 0);
        chk("t6_tx_en", en_cnt, 0);
        hold0 = 1'b0;
        capture(1, 300);
        check_wire("t6", 1, 0);

        // random lengths
        for (int f = 0; f < 4; f++) begin
            push_frame(int'($urandom_range(1, 100)), -1);
            capture(1, 300);
            check_wire("rand", 1, 0);
        end

        chk("rd_en_while_empty", rd_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
